regfile_wb: RTL and testbench
=============================

REGFILE_WB -- requirements
Module: regfile_wb

Interface
REQ-001 SHALL have parameter CNT_W, default 8: width of the killed-write counter.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port we  input  1  write-back enable from control decode.
REQ-005 SHALL have port waddr  input  5  destination register index.
REQ-006 SHALL have port wdata  input  32  write-back data (ALU result).
REQ-007 SHALL have port ovf_in  input  1  ALU signed-overflow indication for the current instruction.
REQ-008 SHALL have port raddr1  input  5  read port 1 index (rs).
REQ-009 SHALL have port raddr2  input  5  read port 2 index (rt).
REQ-010 SHALL have port rdata1  output  32  read port 1 data (ALU operand 1).
REQ-011 SHALL have port rdata2  output  32  read port 2 data (ALU operand 2).
REQ-012 SHALL have port ovf_clr  input  1  clear request for ovf_flag and ovf_cnt.
REQ-013 SHALL have port ovf_flag  output  1  sticky flag: a write was killed by overflow.
REQ-014 SHALL have port ovf_cnt  output  CNT_W  saturating count of killed writes.

Function
REQ-015 SHALL hold 32 registers of 32 bits; register 0 SHALL always read 0 and SHALL never be written.
REQ-016 SHALL read both ports combinationally, with zero-cycle latency from raddr to rdata.
REQ-017 SHALL commit wdata to waddr on the rising clk edge when we=1, ovf_in=0 and waddr!=0; the value is visible on reads from the next cycle.
REQ-018 SHALL kill the write (register unchanged) when we=1 and ovf_in=1.
REQ-019 SHALL ignore ovf_in when we=0: no write, no flag change, no count change.
REQ-020 SHALL define a killed-write event as we=1 and ovf_in=1, independent of waddr (waddr=0 still counts).
REQ-021 SHALL set ovf_flag on the edge following a killed-write event; it holds until cleared.
REQ-022 SHALL increment ovf_cnt by 1 per killed-write event and saturate at 2^CNT_W-1 with no wrap.
REQ-023 SHALL clear ovf_flag to 0 and ovf_cnt to 0 on an edge where ovf_clr=1 and no killed-write event occurs.
REQ-024 SHALL let the event win when ovf_clr=1 coincides with a killed-write event: ovf_flag becomes 1 and ovf_cnt becomes 1.
REQ-025 SHALL treat a flag/count update as two-state only: idle (flag 0) goes to trapped (flag 1) on an event; trapped goes to idle only via REQ-023.
REQ-026 SHALL make read-during-write to the same address per REQ-041/REQ-042; a read of index 0 SHALL return 0 regardless.

Reset
REQ-027 SHALL, while rst_n=0, asynchronously force all 31 writable registers to 0, ovf_flag to 0 and ovf_cnt to 0.
REQ-028 SHALL drive rdata1 and rdata2 to 0 during reset, since all registers read 0.
REQ-029 SHALL take no write, event or clear on a rising edge where rst_n=0.
REQ-030 SHALL resume normal operation on the first rising edge after rst_n deasserts.
REQ-031 SHALL discard any in-flight write when reset asserts mid-cycle; no partial state is retained.

Configuration
REQ-040 SHALL honour the macro REGFILE_BYPASS_EN.
REQ-041 SHALL, when REGFILE_BYPASS_EN is defined, return wdata combinationally on a read port whose index equals waddr (nonzero) while we=1 and ovf_in=0.
REQ-042 SHALL, when REGFILE_BYPASS_EN is undefined, return the stored (pre-write) value in that case.
REQ-043 SHALL never bypass a killed write (ovf_in=1), whether or not the macro is defined.

Verification
REQ-050 Reset then reads: rst_n=0, then 1; raddr1=5, raddr2=31 -> rdata1=0, rdata2=0, ovf_flag=0, ovf_cnt=0.
REQ-051 Basic write: we=1, waddr=3, wdata=32'h1234_5678, ovf_in=0 -> next cycle raddr1=3 gives 32'h1234_5678; a write to waddr=0 with 32'hFFFF_FFFF still reads 0.
REQ-052 Overflow kill: reg 4 = 32'h7FFF_FFFF; we=1, waddr=4, wdata=32'h8000_0000, ovf_in=1 -> reg 4 stays 32'h7FFF_FFFF, ovf_flag=1, ovf_cnt=1.
REQ-053 Saturation and clear: 300 killed-write events (CNT_W=8) -> ovf_cnt=255; ovf_clr=1 with no event -> flag 0, cnt 0; ovf_clr=1 coinciding with an event -> flag 1, cnt 1.
REQ-054 Bypass: we=1, waddr=7, wdata=32'hA5A5_A5A5, raddr2=7 in the same cycle -> rdata2=32'hA5A5_A5A5 with REGFILE_BYPASS_EN, old value without; with ovf_in=1, old value in both builds.
REQ-055 Async reset mid-operation: regs loaded, rst_n low between edges -> rdata immediately 0 and ovf_cnt immediately 0, with no clock edge required.

Source files
------------

// File: rtl/regfile_wb.sv
// 32x32 register file with ALU write-back, overflow write-kill, sticky flag and saturating kill counter.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_wb #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [4:0]       waddr,
    input  logic [31:0]      wdata,
    input  logic             ovf_in,
    input  logic [4:0]       raddr1,
    input  logic [4:0]       raddr2,
    output logic [31:0]      rdata1,
    output logic [31:0]      rdata2,
    input  logic             ovf_clr,
    output logic             ovf_flag,
    output logic [CNT_W-1:0] ovf_cnt
);

    typedef enum logic {IDLE, TRAPPED} ovf_state_e;

    logic [31:0]      regs_q [32];
    logic [31:0]      regs_d [32];
    ovf_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wr_en;
    logic             kill;

    assign wr_en = we && !ovf_in && (waddr != 5'd0);
    assign kill  = we && ovf_in;

    always_comb begin
        regs_d = regs_q;
        if (wr_en) regs_d[waddr] = wdata;
        regs_d[0] = '0;
    end

    // The event beats a coincident clear, so the count restarts at 1.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (kill) begin
            state_d = TRAPPED;
            if (ovf_clr)              cnt_d = CNT_W'(1);
            else if (cnt_q != '1)     cnt_d = cnt_q + CNT_W'(1);
        end else if (ovf_clr) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) regs_q[i] <= '0;
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            regs_q  <= regs_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        rdata1 = (raddr1 == 5'd0) ? 32'd0 : regs_q[raddr1];
        rdata2 = (raddr2 == 5'd0) ? 32'd0 : regs_q[raddr2];
`ifdef REGFILE_BYPASS_EN
        // Forwarding is suppressed in reset so reads stay at 0 while rst_n is low.
        if (rst_n && wr_en && raddr1 == waddr) rdata1 = wdata;
        if (rst_n && wr_en && raddr2 == waddr) rdata2 = wdata;
`endif
    end

    assign ovf_flag = (state_q == TRAPPED);
    assign ovf_cnt  = cnt_q;

endmodule

// File: tb/tb_regfile_wb.sv
// Randomized bench for regfile_wb against an array-based reference model of the register file and overflow counter.
module tb_regfile_wb;

    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             we;
    logic [4:0]       waddr;
    logic [31:0]      wdata;
    logic             ovf_in;
    logic [4:0]       raddr1;
    logic [4:0]       raddr2;
    logic [31:0]      rdata1;
    logic [31:0]      rdata2;
    logic             ovf_clr;
    logic             ovf_flag;
    logic [CNT_W-1:0] ovf_cnt;

    regfile_wb #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .ovf_in(ovf_in), .raddr1(raddr1), .raddr2(raddr2),
        .rdata1(rdata1), .rdata2(rdata2), .ovf_clr(ovf_clr),
        .ovf_flag(ovf_flag), .ovf_cnt(ovf_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_regs [32];
    bit          m_flag;
    int          m_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
        if (we && !ovf_in && a == waddr) return wdata;
`endif
        return m_regs[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_flag = 1'b0;
        m_cnt  = 0;
    endtask

    // Drive one instruction, check reads and status mid-cycle, then advance the model past the edge.
    task automatic cycle(input logic w, input logic [4:0] wa, input logic [31:0] wd, input logic ov,
                         input logic clr, input logic [4:0] r1, input logic [4:0] r2, input string tag);
        we = w; waddr = wa; wdata = wd; ovf_in = ov; ovf_clr = clr; raddr1 = r1; raddr2 = r2;
        #1;
        chk({tag, ".rd1"}, rdata1, exp_rd(r1));
        chk({tag, ".rd2"}, rdata2, exp_rd(r2));
        chk({tag, ".flag"}, {31'd0, ovf_flag}, {31'd0, m_flag});
        chk({tag, ".cnt"}, {{(32-CNT_W){1'b0}}, ovf_cnt}, m_cnt);
        @(posedge clk);
        if (w && !ov && wa != 5'd0) m_regs[wa] = wd;
        if (w && ov) begin
            m_flag = 1'b1;
            m_cnt  = clr ? 1 : (m_cnt < CNT_MAX ? m_cnt + 1 : m_cnt);
        end else if (clr) begin
            m_flag = 1'b0;
            m_cnt  = 0;
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0; ovf_in = 1'b0;
        ovf_clr = 1'b0; raddr1 = 5'd5; raddr2 = 5'd31;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("rst.rd1", rdata1, 32'd0);
        chk("rst.rd2", rdata2, 32'd0);
        rst_n = 1'b1;

        cycle(0, 0, 0, 0, 0, 5, 31, "post_rst");
        cycle(1, 3, 32'h1234_5678, 0, 0, 0, 0, "wr3");
        cycle(1, 0, 32'hFFFF_FFFF, 0, 0, 3, 0, "rd3_wr0");
        cycle(0, 0, 0, 0, 0, 0, 3, "rd0");
        chk("reg3", rdata2, 32'h1234_5678);

        cycle(1, 4, 32'h7FFF_FFFF, 0, 0, 4, 0, "wr4");
        cycle(1, 4, 32'h8000_0000, 1, 0, 4, 4, "kill4");
        cycle(0, 0, 0, 0, 0, 4, 0, "rd4");
        chk("kill.flag", {31'd0, ovf_flag}, 32'd1);
        chk("kill.cnt", {24'd0, ovf_cnt}, 32'd1);
        cycle(0, 4, 0, 1, 0, 4, 0, "noweovf");

        for (int i = 0; i < 300; i++) cycle(1, 5'(i), 32'(i), 1, 0, 5'(i), 4, "sat");
        cycle(0, 0, 0, 0, 0, 4, 0, "sat_end");
        chk("sat.cnt", {24'd0, ovf_cnt}, 32'd255);
        cycle(0, 0, 0, 0, 1, 0, 0, "clr");
        cycle(1, 0, 0, 1, 1, 0, 0, "clr_evt");
        chk("clr_evt.cnt", {24'd0, ovf_cnt}, 32'd1);
        cycle(0, 0, 0, 0, 0, 0, 0, "after_clr_evt");

        cycle(1, 7, 32'h0BAD_F00D, 0, 0, 0, 0, "wr7");
        cycle(1, 7, 32'hA5A5_A5A5, 0, 0, 7, 7, "byp");
        cycle(1, 7, 32'h5A5A_5A5A, 1, 0, 7, 7, "byp_kill");
        chk("byp_kill.rd2", rdata2, 32'hA5A5_A5A5);

        for (int i = 0; i < 400; i++) begin
            logic [4:0] wa;
            wa = 5'($urandom_range(0, 31));
            cycle($urandom_range(0, 3) != 0, wa, $urandom, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 15) == 0,
                  ($urandom_range(0, 1) != 0) ? wa : 5'($urandom_range(0, 31)),
                  5'($urandom_range(0, 31)), "rand");
        end

        cycle(1, 3, 32'hDEAD_BEEF, 0, 0, 0, 0, "pre_ar_wr");
        cycle(1, 9, 32'h1, 1, 0, 3, 0, "pre_ar_kill");
        we = 1'b1; waddr = 5'd3; wdata = 32'hCAFE_0001; ovf_in = 1'b0; raddr1 = 5'd3; raddr2 = 5'd4;
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar.rd1", rdata1, 32'd0);
        chk("ar.rd2", rdata2, 32'd0);
        chk("ar.cnt", {24'd0, ovf_cnt}, 32'd0);
        chk("ar.flag", {31'd0, ovf_flag}, 32'd0);
        model_reset();
        we = 1'b1; waddr = 5'd9; wdata = 32'h7777_7777; ovf_in = 1'b0;
        @(posedge clk);
        ovf_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cycle(0, 0, 0, 0, 0, 3, 9, "post_ar");
        cycle(1, 9, 32'h2468_ACE0, 0, 0, 9, 9, "resume");
        cycle(0, 0, 0, 0, 0, 9, 3, "resume_rd");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
